// File: rtl/calc_pkg.sv
// Shared calculator definitions: operand width, op codes and sequencer states.
package calc_pkg;

  localparam int unsigned N_DEF = 4;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // ST_M_CHK is a decision point that resolves in zero time, so it is never held.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_M_CHK = 4'd2,
    ST_M_ADD = 4'd3,
    ST_M_SH  = 4'd4,
    ST_D_OVF = 4'd5,
    ST_D_SH  = 4'd6,
    ST_D_CHK = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shift-add multiplier and the restoring divider.
// It drives the shared shift register and the add/sub ALU.
module muldiv_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] y,
  input  logic         c,
  input  logic         no_borrow,
  output logic         clr_acc,
  output logic         ld_multiplier,
  output logic         ld_dividend,
  output logic         alu_sub,
  output logic         ad,
  output logic         q_set,
  output logic         sh,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_mul_pick;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_op;
  logic          w_op_nxt;
  logic          r_err;
  logic          w_err_nxt;

  // Multiplier bit decision: add before the shift only when the current bit is 1.
  assign w_mul_pick = c ? ST_M_ADD : ST_M_SH;

  // State, iteration counter, latched op and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MUL;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic and strobe decode from the held state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_op_nxt      = r_op;
    w_err_nxt     = r_err;
    clr_acc       = 1'b0;
    ld_multiplier = 1'b0;
    ld_dividend   = 1'b0;
    alu_sub       = 1'b0;
    ad            = 1'b0;
    q_set         = 1'b0;
    sh            = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_op_nxt    = op;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end

      ST_LOAD: begin
        busy    = 1'b1;
        clr_acc = 1'b1;
        if (r_op == OP_DIV) begin
          ld_dividend = 1'b1;
          w_state_nxt = ST_D_OVF;
        end else begin
          ld_multiplier = 1'b1;
          w_state_nxt   = w_mul_pick;
        end
      end

      ST_M_CHK: begin
        busy        = 1'b1;
        w_state_nxt = w_mul_pick;
      end

      ST_M_ADD: begin
        busy        = 1'b1;
        ad          = 1'b1;
        w_state_nxt = ST_M_SH;
      end

      ST_M_SH: begin
        busy      = 1'b1;
        sh        = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = w_mul_pick;
        end
      end

      ST_D_OVF: begin
        busy    = 1'b1;
        alu_sub = 1'b1;
        if ((y == '0) || no_borrow) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_D_SH;
        end
      end

      ST_D_SH: begin
        busy        = 1'b1;
        sh          = 1'b1;
        w_state_nxt = ST_D_CHK;
      end

      ST_D_CHK: begin
        busy      = 1'b1;
        alu_sub   = 1'b1;
        ad        = no_borrow;
        q_set     = no_borrow;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_D_SH;
        end
      end

      ST_DONE: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
